// File: rtl/cla_subtractor_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : carry_lookahead_subtractor
//  Description : N-bit combinational subtractor, o_diff = i_a - i_b - i_bin.
//                Every borrow is formed directly from generate/propagate
//                terms and the borrow-in, so no borrow ripples bit to bit.
//  Ports       : i_a, i_b  [N-1:0]  operands
//                i_bin              borrow-in
//                o_diff   [N-1:0]   difference
//                o_bout             borrow-out
//  Revision    : 1.0  initial release
// ============================================================================
module carry_lookahead_subtractor #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_bin,
    output logic [N-1:0] o_diff,
    output logic         o_bout
);
    // Bit i generates a borrow when a=0,b=1 and passes one on when a==b.
    logic [N-1:0] w_gen;
    logic [N-1:0] w_prop;
    logic [N:0]   w_borrow;

    assign w_gen  = ~i_a & i_b;
    assign w_prop = ~(i_a ^ i_b);

    // Sum-of-products expansion:
    // borrow[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]bin
    always_comb begin
        logic v_term;
        logic v_pp;
        w_borrow    = '0;
        w_borrow[0] = i_bin;
        for (int i = 0; i < N; i++) begin
            v_term = 1'b0;
            v_pp   = 1'b1;
            for (int j = i; j >= 0; j--) begin
                v_term = v_term | (v_pp & w_gen[j]);
                v_pp   = v_pp & w_prop[j];
            end
            w_borrow[i+1] = v_term | (v_pp & i_bin);
        end
    end

    assign o_diff = i_a ^ i_b ^ w_borrow[N-1:0];
    assign o_bout = w_borrow[N];
endmodule

// ============================================================================
//  Module      : cla_subtractor_seq_ctrl
//  Description : Limb-serial wide subtractor, diff = a - b - bin over
//                N*LIMBS bits. One N-bit lookahead subtractor is reused once
//                per cycle, LSB limb first, with the borrow carried between
//                limbs in a register. Valid/ready on both sides.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid / in_ready    operand handshake (a, b, bin)
//                out_valid / out_ready  result handshake (diff, bout, zero)
//                busy                   operation in RUN or DONE
//  Revision    : 1.0  initial release
// ============================================================================
module cla_subtractor_seq_ctrl #(
    parameter int N     = 8,
    parameter int LIMBS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*LIMBS-1:0] a,
    input  logic [N*LIMBS-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*LIMBS-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             busy
);
    localparam int c_W     = N * LIMBS;
    localparam int c_IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(LIMBS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_W-1:0]     r_a;
    logic [c_W-1:0]     r_b;
    logic [c_W-1:0]     r_diff;
    logic [c_W-1:0]     w_diff_next;
    logic               r_borrow;
    logic               r_zero;
    logic [c_IDX_W-1:0] r_idx;
    logic [N-1:0]       w_limb_diff;
    logic               w_limb_bout;
    logic               w_accept;
    logic               w_last;

    carry_lookahead_subtractor #(.N(N)) u_sub (
        .i_a    (r_a[r_idx*N +: N]),
        .i_b    (r_b[r_idx*N +: N]),
        .i_bin  (r_borrow),
        .o_diff (w_limb_diff),
        .o_bout (w_limb_bout)
    );

    assign w_last = (r_idx == c_LAST_IDX);

    // Full-width view of the result including the limb being produced now,
    // so the zero flag can be registered on the same edge as the last limb.
    always_comb begin
        w_diff_next                = r_diff;
        w_diff_next[r_idx*N +: N]  = w_limb_diff;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state and outputs ----------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                w_accept = in_valid;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                busy         = 1'b0;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_idx    <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_idx    <= '0;
        end else if (r_state == S_RUN) begin
            r_diff   <= w_diff_next;
            r_borrow <= w_limb_bout;
            r_idx    <= r_idx + c_IDX_W'(1);
            if (w_last) begin
                r_zero <= (w_diff_next == '0);
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_borrow;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_cla_subtractor_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_subtractor_seq_ctrl
//  Description : Directed self-checking bench for cla_subtractor_seq_ctrl
//                (N=8, LIMBS=4) with an expected-result queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cla_subtractor_seq_ctrl;
    localparam int N     = 8;
    localparam int LIMBS = 4;
    localparam int W     = N * LIMBS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
    } exp_t;

    exp_t sb_q[$];

    cla_subtractor_seq_ctrl #(.N(N), .LIMBS(LIMBS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: 33-bit unsigned subtraction; bit W is the borrow-out.
    task automatic push_exp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
        logic [W:0] full;
        exp_t e;
        full   = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bv_in};
        e.diff = full[W-1:0];
        e.bout = full[W];
        e.zero = (full[W-1:0] == '0);
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, ":sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ":diff"}, diff, e.diff);
            chk({tag, ":bout"}, bout, e.bout);
            chk({tag, ":zero"}, zero, e.zero);
        end
    endtask

    // Called at the negedge right after the accept edge; returns at the
    // negedge where out_valid is first seen and checks the latency.
    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ":latency"}, n, LIMBS);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in,
                          input string tag);
        chk({tag, ":in_ready"}, in_ready, 1);
        a        = av;
        b        = bv;
        bin      = bv_in;
        in_valid = 1'b1;
        push_exp(av, bv, bv_in);
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        bin      = ~bv_in;
        chk({tag, ":busy"}, busy, 1);
        chk({tag, ":in_ready_run"}, in_ready, 0);
        wait_out(tag);
        pop_check(tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ":out_valid_after"}, out_valid, 0);
        chk({tag, ":idle"}, in_ready, 1);
    endtask

    logic [W-1:0] bb_a [3] = '{32'h0000_0010, 32'h8000_0000, 32'h0000_FFFF};
    logic [W-1:0] bb_b [3] = '{32'h0000_0011, 32'h0000_0001, 32'h0000_FFFF};
    logic         bb_c [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        int acc_t [3];
        int n_acc;
        int n_res;
        int iter;
        bit pending;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst:in_ready", in_ready, 1);
        chk("rst:out_valid", out_valid, 0);
        chk("rst:busy", busy, 0);
        chk("rst:diff", diff, 0);
        chk("rst:bout", bout, 0);
        chk("rst:zero", zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic and borrow-propagation cases
        run_op(32'h1234_5678, 32'h0234_5678, 1'b0, "basic");
        run_op(32'h0000_0100, 32'h0000_0001, 1'b0, "limb_borrow");
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, "wrap");
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, "eq_bin1");
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "eq_zero");

        // Backpressure with ignored in_valid pulses
        a        = 32'h1111_1111;
        b        = 32'h0000_0001;
        bin      = 1'b0;
        in_valid = 1'b1;
        push_exp(32'h1111_1111, 32'h0000_0001, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out("bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = (i >= 1 && i <= 3);
            a        = 32'hFFFF_FFFF;
            b        = 32'h0000_0000;
            @(negedge clk);
            chk("bp:out_valid", out_valid, 1);
            chk("bp:in_ready", in_ready, 0);
            if (sb_q.size() != 0) begin
                chk("bp:diff_stable", diff, sb_q[0].diff);
                chk("bp:bout_stable", bout, sb_q[0].bout);
            end
        end
        in_valid = 1'b0;
        pop_check("bp");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp:out_valid_drop", out_valid, 0);
        chk("bp:in_ready_back", in_ready, 1);
        chk("bp:busy_clear", busy, 0);

        // Reset in the middle of RUN
        a        = 32'hAAAA_AAAA;
        b        = 32'h5555_5555;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst:in_ready", in_ready, 1);
        chk("midrst:out_valid", out_valid, 0);
        chk("midrst:diff", diff, 0);
        chk("midrst:busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'd5, 32'd3, 1'b0, "post_rst");

        // Back-to-back stream with in_valid held high
        n_acc     = 0;
        n_res     = 0;
        iter      = 0;
        pending   = 1'b0;
        acc_t     = '{0, 0, 0};
        out_ready = 1'b1;
        a         = bb_a[0];
        b         = bb_b[0];
        bin       = bb_c[0];
        in_valid  = 1'b1;
        while (n_res < 3 && iter < 100) begin
            if (out_valid) begin
                pop_check("b2b");
                n_res++;
            end
            if (in_valid && in_ready) begin
                push_exp(a, b, bin);
                acc_t[n_acc] = cyc;
                n_acc++;
                pending = 1'b1;
            end
            @(negedge clk);
            iter++;
            if (pending) begin
                pending = 1'b0;
                if (n_acc < 3) begin
                    a   = bb_a[n_acc];
                    b   = bb_b[n_acc];
                    bin = bb_c[n_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b:results", n_res, 3);
        chk("b2b:spacing01", acc_t[1] - acc_t[0], LIMBS + 2);
        chk("b2b:spacing12", acc_t[2] - acc_t[1], LIMBS + 2);
        chk("b2b:sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
